matrix_result_streamer: RTL and testbench

//  Reader side of the result matrix R written by the multiplier controller.

---
 rtl/matrix_result_streamer.sv | 164 ++++++++++++++++
 tb/tb_matrix_result_streamer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_streamer.sv
// Walks the N x N result matrix row-major and streams each element out with row/col/last tags.
// Latency: read issued the cycle after start, element valid two cycles later; 3 cycles/element minimum.
// Backpressure: element and tags held stable in PRESENT until out_ready; no further reads meanwhile.
module matrix_result_streamer #(
  parameter int N     = 4,
  parameter int IDX_W = 2,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_row,
  output logic [IDX_W-1:0] rd_col,
  input  logic [DW-1:0]    rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [IDX_W-1:0] out_row,
  output logic [IDX_W-1:0] out_col,
  output logic             out_last
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [IDX_W-1:0] rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [IDX_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic             out_last_q, out_last_d;
  logic [IDX_W-1:0] nxt_row, nxt_col;

  // Row-major successor of the current index; only used when not on the last element.
  always_comb begin
    nxt_row = row_q;
    nxt_col = col_q + 1'b1;
    if (col_q == LAST_IDX) begin
      nxt_col = '0;
      nxt_row = row_q + 1'b1;
    end
  end

  // Next-state and registered-output logic; every output is computed one cycle ahead.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d    = '0;
          col_d    = '0;
          rd_en_d  = 1'b1;
          rd_row_d = '0;
          rd_col_d = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // rd_data carries the element addressed during ISSUE.
        out_data_d  = rd_data;
        out_row_d   = row_q;
        out_col_d   = col_q;
        out_last_d  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
        out_valid_d = 1'b1;
        state_d     = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            row_d    = nxt_row;
            col_d    = nxt_col;
            rd_en_d  = 1'b1;
            rd_row_d = nxt_row;
            rd_col_d = nxt_col;
            state_d  = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_row    = rd_row_q;
  assign rd_col    = rd_col_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: N=4 instance plus an N=1 instance.
// Result memory modelled as a 1-cycle synchronous read of R[r][c]=16*r+c (N=4) / 0xBEEF (N=1).
// Drives and samples on the falling edge.
module tb_matrix_result_streamer;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic        busy, done, rd_en, out_valid, out_last;
  logic [1:0]  rd_row, rd_col, out_row, out_col;
  logic [15:0] rd_data, out_data;

  logic        start1, out_ready1;
  logic        busy1, done1, rd_en1, out_valid1, out_last1;
  logic [0:0]  rd_row1, rd_col1, out_row1, out_col1;
  logic [15:0] rd_data1, out_data1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  matrix_result_streamer #(.N(4), .IDX_W(2), .DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  matrix_result_streamer #(.N(1), .IDX_W(1), .DW(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .rd_row(rd_row1), .rd_col(rd_col1), .rd_data(rd_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_row(out_row1), .out_col(out_col1), .out_last(out_last1)
  );

  // Synchronous result memories; garbage when not read so stale data would be noticed.
  always @(posedge clk) begin
    rd_data  <= rd_en ? ({12'd0, rd_row, 2'b00} * 16'd4 + {14'd0, rd_col}) : 16'hDEAD;
    rd_data1 <= rd_en1 ? ((rd_row1 == 1'b0 && rd_col1 == 1'b0) ? 16'hBEEF : 16'h0000) : 16'hDEAD;
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0; out_ready = 1'b1; out_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, rd_en, out_valid, out_last, out_data, out_row, out_col} !== 23'd0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b rd_en=%b vld=%b last=%b data=%h, want all 0",
               busy, done, rd_en, out_valid, out_last, out_data);
    end
    tests++;
    if ({busy1, done1, rd_en1, out_valid1, out_data1} !== 20'd0) begin
      fails++;
      $display("FAIL reset_n1: busy=%b done=%b rd_en=%b vld=%b data=%h, want all 0",
               busy1, done1, rd_en1, out_valid1, out_data1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full();
    int idx = 0, done_cnt = 0, done_cyc = -1, idle_cyc = -1, first_vld = -1;
    logic [1:0]  er, ec;
    logic [15:0] ed;
    out_ready = 1'b1;
    start = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 0) begin
        tests++;
        if (rd_en !== 1'b1 || rd_row !== 2'd0 || rd_col !== 2'd0) begin
          fails++;
          $display("FAIL full_first_read: rd_en=%b row=%0d col=%0d, want 1 0 0", rd_en, rd_row, rd_col);
        end
      end
      if (out_valid === 1'b1) begin
        if (first_vld < 0) first_vld = cyc;
        er = 2'(idx / 4); ec = 2'(idx % 4); ed = 16'(16 * (idx / 4) + idx % 4);
        tests++;
        if (out_data !== ed || out_row !== er || out_col !== ec || out_last !== (idx == 15)) begin
          fails++;
          $display("FAIL full_elem%0d: got %h r%0d c%0d last=%b, want %h r%0d c%0d last=%b",
                   idx, out_data, out_row, out_col, out_last, ed, er, ec, idx == 15);
        end
        idx++;
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (busy === 1'b0 && idle_cyc < 0) idle_cyc = cyc;
    end
    tests++;
    if (idx != 16) begin fails++; $display("FAIL full_count: got %0d elements, want 16", idx); end
    tests++;
    if (first_vld != 2) begin fails++; $display("FAIL full_first_valid: cycle %0d, want 2", first_vld); end
    tests++;
    if (done_cnt != 1 || done_cyc != 48) begin
      fails++;
      $display("FAIL full_done: %0d pulses at cycle %0d, want 1 at 48", done_cnt, done_cyc);
    end
    tests++;
    if (idle_cyc != 49) begin fails++; $display("FAIL full_busy_fall: cycle %0d, want 49", idle_cyc); end
  endtask

  task automatic test_backpressure();
    int idx = 0, done_cnt = 0;
    logic        stall = 1'b0;
    logic [15:0] sd, ed;
    logic [1:0]  sr, sc;
    start = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (stall) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== sd || out_row !== sr || out_col !== sc) begin
          fails++;
          $display("FAIL bp_stable: vld=%b %h r%0d c%0d, want 1 %h r%0d c%0d",
                   out_valid, out_data, out_row, out_col, sd, sr, sc);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      stall = 1'b0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          ed = 16'(16 * (idx / 4) + idx % 4);
          tests++;
          if (out_data !== ed || out_row !== 2'(idx / 4) || out_col !== 2'(idx % 4)) begin
            fails++;
            $display("FAIL bp_elem%0d: got %h r%0d c%0d, want %h", idx, out_data, out_row, out_col, ed);
          end
          idx++;
        end else begin
          stall = 1'b1; sd = out_data; sr = out_row; sc = out_col;
        end
      end
      if (done === 1'b1) done_cnt++;
    end
    out_ready = 1'b1;
    tests++;
    if (idx != 16 || done_cnt != 1) begin
      fails++;
      $display("FAIL bp_count: %0d elements %0d done, want 16 and 1", idx, done_cnt);
    end
  endtask

  task automatic test_hold();
    int hold = 0;
    logic after13 = 1'b0, seen20 = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b1;
      if (out_valid === 1'b1) begin
        if (out_row == 2'd1 && out_col == 2'd3 && hold < 10) begin
          out_ready = 1'b0;
          hold++;
          tests++;
          if (out_data !== 16'h0013) begin
            fails++;
            $display("FAIL hold_data: got %h, want 0013", out_data);
          end
        end else begin
          if (after13) begin
            seen20 = 1'b1;
            tests++;
            if (out_row !== 2'd2 || out_col !== 2'd0 || out_data !== 16'h0020) begin
              fails++;
              $display("FAIL hold_wrap: got %h r%0d c%0d, want 0020 r2 c0", out_data, out_row, out_col);
            end
          end
          after13 = (out_row == 2'd1 && out_col == 2'd3);
        end
      end else if (hold > 0 && hold < 10) begin
        tests++; fails++;
        $display("FAIL hold_valid: out_valid=0 after %0d stalled cycles, want 1", hold);
        hold = 10;
      end
    end
    tests++;
    if (hold != 10 || !seen20) begin
      fails++;
      $display("FAIL hold_seen: held %0d cycles, wrap element seen=%b, want 10 and 1", hold, seen20);
    end
  endtask

  task automatic test_start_ignored();
    int rdc = 0, dc = 0;
    logic pi = 1'b0, pp = 1'b0, pd = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en === 1'b1) begin
        tests++;
        if (rd_row !== 2'(rdc / 4) || rd_col !== 2'(rdc % 4)) begin
          fails++;
          $display("FAIL ign_read%0d: r%0d c%0d, want r%0d c%0d", rdc, rd_row, rd_col, rdc / 4, rdc % 4);
        end
        rdc++;
        if (rd_row == 2'd1 && rd_col == 2'd0 && !pi) begin start = 1'b1; pi = 1'b1; end
      end
      if (out_valid === 1'b1 && out_row == 2'd2 && out_col == 2'd2 && !pp) begin start = 1'b1; pp = 1'b1; end
      if (done === 1'b1) begin
        dc++;
        if (!pd) begin start = 1'b1; pd = 1'b1; end
      end
    end
    tests++;
    if (rdc != 16 || dc != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ign_counts: reads=%0d done=%0d busy=%b, want 16 1 0", rdc, dc, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic hit = 1'b0, got_rd = 1'b0, got_el = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    for (int cyc = 0; cyc < 60 && !hit; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid === 1'b1 && out_row == 2'd2 && out_col == 2'd1) begin rst = 1'b1; hit = 1'b1; end
    end
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (!hit || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || out_data !== 16'd0) begin
      fails++;
      $display("FAIL rstmid: hit=%b vld=%b busy=%b done=%b rd_en=%b data=%h, want 1 0 0 0 0 0000",
               hit, out_valid, busy, done, rd_en, out_data);
    end
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en === 1'b1 && !got_rd) begin
        got_rd = 1'b1;
        tests++;
        if (rd_row !== 2'd0 || rd_col !== 2'd0) begin
          fails++;
          $display("FAIL rstmid_read: r%0d c%0d, want r0 c0", rd_row, rd_col);
        end
      end
      if (out_valid === 1'b1 && !got_el) begin
        got_el = 1'b1;
        tests++;
        if (out_data !== 16'h0000 || out_row !== 2'd0 || out_col !== 2'd0 || out_last !== 1'b0) begin
          fails++;
          $display("FAIL rstmid_elem: %h r%0d c%0d last=%b, want 0000 r0 c0 0", out_data, out_row, out_col, out_last);
        end
      end
    end
    tests++;
    if (!got_rd || !got_el || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_restart: read=%b elem=%b busy=%b, want 1 1 0", got_rd, got_el, busy);
    end
  endtask

  task automatic test_n1();
    int vcnt = 0, rcnt = 0, done_cyc = -1;
    start1 = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (rd_en1 === 1'b1) rcnt++;
      if (out_valid1 === 1'b1) begin
        vcnt++;
        tests++;
        if (cyc != 2 || out_data1 !== 16'hBEEF || out_last1 !== 1'b1 || out_row1 !== 1'b0 || out_col1 !== 1'b0) begin
          fails++;
          $display("FAIL n1_elem: cycle %0d %h last=%b, want cycle 2 BEEF last=1", cyc, out_data1, out_last1);
        end
      end
      if (done1 === 1'b1) done_cyc = cyc;
      if (cyc == 4) begin
        tests++;
        if (busy1 !== 1'b0) begin fails++; $display("FAIL n1_busy: got %b at cycle 4, want 0", busy1); end
      end
    end
    tests++;
    if (vcnt != 1 || rcnt != 1 || done_cyc != 3) begin
      fails++;
      $display("FAIL n1_counts: elems=%0d reads=%0d done_cycle=%0d, want 1 1 3", vcnt, rcnt, done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_backpressure();
    test_hold();
    test_start_ignored();
    test_reset_mid();
    test_n1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
